// File: rtl/dcm_sp_model.sv
// dcm_sp_model: single-clock stand-in for a DCM_SP clock manager.
// CLK0 is CLKIN passed straight through. CLKFX is a strobe that fires
// CLKFX_MULTIPLY times in every CLKFX_DIVIDE locked cycles, driven by a
// phase accumulator. CLKDV is CLKIN divided by CLKDV_DIVIDE at 50% duty.
// LOCKED rises a fixed number of CLKIN edges after reset is released.
module dcm_sp_model #(
    parameter int CLKFX_MULTIPLY = 25,
    parameter int CLKFX_DIVIDE   = 32,
    parameter int CLKDV_DIVIDE   = 2,
    parameter int LOCK_CYCLES    = 16
) (
    input  logic CLKIN,
    input  logic RST_N,
    input  logic CLKFB,
    output logic CLK0,
    output logic CLKFX,
    output logic CLKDV,
    output logic LOCKED
);

    localparam bit PARAM_OK =
        (CLKFX_MULTIPLY >= 1) && (CLKFX_MULTIPLY <= CLKFX_DIVIDE) &&
        (CLKFX_DIVIDE >= 1) && (CLKFX_DIVIDE <= 256) &&
        (CLKDV_DIVIDE >= 2) && (CLKDV_DIVIDE <= 16) && ((CLKDV_DIVIDE % 2) == 0) &&
        (LOCK_CYCLES >= 1) && (LOCK_CYCLES <= 255);

    // One extra bit so acc + M (always < 2*D) never overflows.
    localparam int AW = $clog2(CLKFX_DIVIDE) + 1;

    // CLKFB exists only so the port list matches the real primitive.
    logic unused_clkfb;
    assign unused_clkfb = CLKFB;

    // Pass-through clock, valid even while reset is asserted.
    assign CLK0 = CLKIN;

    generate
        if (!PARAM_OK) begin : g_bad
            $error("dcm_sp_model: illegal parameter set M=%0d D=%0d DV=%0d LOCK=%0d",
                   CLKFX_MULTIPLY, CLKFX_DIVIDE, CLKDV_DIVIDE, LOCK_CYCLES);
            assign CLKFX  = 1'b0;
            assign CLKDV  = 1'b0;
            assign LOCKED = 1'b0;
        end else begin : g_ok
            localparam logic [AW-1:0] M_W      = AW'(CLKFX_MULTIPLY);
            localparam logic [AW-1:0] D_W      = AW'(CLKFX_DIVIDE);
            localparam logic [7:0]    LOCK_TGT = 8'(LOCK_CYCLES);
            localparam logic [3:0]    DV_TERM  = 4'(CLKDV_DIVIDE / 2 - 1);

            logic [7:0]    lock_cnt;
            logic          locked_q;
            logic [AW-1:0] acc;
            logic [AW-1:0] sum;
            logic          fx_q;
            logic [3:0]    dv_cnt;
            logic          dv_q;

            assign sum = acc + M_W;

            // Lock counter: saturates at LOCK_CYCLES; LOCKED sets on the edge it gets there.
            always_ff @(posedge CLKIN or negedge RST_N) begin
                if (!RST_N) begin
                    lock_cnt <= 8'd0;
                    locked_q <= 1'b0;
                end else begin
                    if (lock_cnt != LOCK_TGT)
                        lock_cnt <= lock_cnt + 8'd1;
                    if (lock_cnt == LOCK_TGT - 8'd1)
                        locked_q <= 1'b1;
                end
            end

            // Phase accumulator: emits a one-cycle CLKFX pulse on every wrap past D.
            always_ff @(posedge CLKIN or negedge RST_N) begin
                if (!RST_N) begin
                    acc  <= '0;
                    fx_q <= 1'b0;
                end else if (!locked_q) begin
                    acc  <= '0;
                    fx_q <= 1'b0;
                end else if (sum >= D_W) begin
                    acc  <= sum - D_W;
                    fx_q <= 1'b1;
                end else begin
                    acc  <= sum;
                    fx_q <= 1'b0;
                end
            end

            // Half-period counter: toggles CLKDV every CLKDV_DIVIDE/2 locked edges.
            always_ff @(posedge CLKIN or negedge RST_N) begin
                if (!RST_N) begin
                    dv_cnt <= 4'd0;
                    dv_q   <= 1'b0;
                end else if (!locked_q) begin
                    dv_cnt <= 4'd0;
                    dv_q   <= 1'b0;
                end else if (dv_cnt == DV_TERM) begin
                    dv_cnt <= 4'd0;
                    dv_q   <= ~dv_q;
                end else begin
                    dv_cnt <= dv_cnt + 4'd1;
                end
            end

            assign CLKFX  = fx_q;
            assign CLKDV  = dv_q;
            assign LOCKED = locked_q;
        end
    endgenerate

endmodule

// File: tb/tb_dcm_sp_model.sv
// Directed bench for dcm_sp_model. Four instances share CLKIN/RST_N:
//   u_a: 25/32, CLKDV_DIVIDE=2, CLKFB tied to its CLK0
//   u_b: 8/8,   CLKDV_DIVIDE=4
//   u_c: 1/256, CLKDV_DIVIDE=16
//   u_d: same as u_a but CLKFB toggled at random times
// Outputs are sampled on the falling edge of CLKIN.
module tb_dcm_sp_model;

    logic clkin   = 1'b0;
    logic rst_n   = 1'b0;
    logic fb_rand = 1'b0;

    logic clk0_a, fx_a, dv_a, lk_a;
    logic clk0_b, fx_b, dv_b, lk_b;
    logic clk0_c, fx_c, dv_c, lk_c;
    logic clk0_d, fx_d, dv_d, lk_d;

    int checks = 0;
    int errors = 0;

    // Hand-computed traces for the first locked edges.
    // acc for 25/32 goes 25,18,11,4,29,22 -> pulses 0,1,1,1,0,1
    logic exp_fx_a [0:5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    // CLKDV_DIVIDE=4: first rise on the 2nd locked edge, then 2 high / 2 low
    logic exp_dv_b [0:7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    dcm_sp_model #(.CLKFX_MULTIPLY(25), .CLKFX_DIVIDE(32), .CLKDV_DIVIDE(2), .LOCK_CYCLES(16)) u_a (
        .CLKIN(clkin), .RST_N(rst_n), .CLKFB(clk0_a),
        .CLK0(clk0_a), .CLKFX(fx_a), .CLKDV(dv_a), .LOCKED(lk_a));

    dcm_sp_model #(.CLKFX_MULTIPLY(8), .CLKFX_DIVIDE(8), .CLKDV_DIVIDE(4), .LOCK_CYCLES(16)) u_b (
        .CLKIN(clkin), .RST_N(rst_n), .CLKFB(clk0_b),
        .CLK0(clk0_b), .CLKFX(fx_b), .CLKDV(dv_b), .LOCKED(lk_b));

    dcm_sp_model #(.CLKFX_MULTIPLY(1), .CLKFX_DIVIDE(256), .CLKDV_DIVIDE(16), .LOCK_CYCLES(16)) u_c (
        .CLKIN(clkin), .RST_N(rst_n), .CLKFB(clk0_c),
        .CLK0(clk0_c), .CLKFX(fx_c), .CLKDV(dv_c), .LOCKED(lk_c));

    dcm_sp_model #(.CLKFX_MULTIPLY(25), .CLKFX_DIVIDE(32), .CLKDV_DIVIDE(2), .LOCK_CYCLES(16)) u_d (
        .CLKIN(clkin), .RST_N(rst_n), .CLKFB(fb_rand),
        .CLK0(clk0_d), .CLKFX(fx_d), .CLKDV(dv_d), .LOCKED(lk_d));

    // Clock and reset block
    always #5 clkin = ~clkin;

    initial begin
        forever begin
            #($urandom_range(1, 7));
            fb_rand = ~fb_rand;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // CLK0 follows CLKIN in both phases, in reset and out, whatever CLKFB does.
    always @(posedge clkin) begin
        #1;
        check("clk0_a_hi", clk0_a, 1'b1);
        check("clk0_d_hi", clk0_d, 1'b1);
    end

    always @(negedge clkin) begin
        #1;
        check("clk0_a_lo", clk0_a, 1'b0);
        check("clk0_d_lo", clk0_d, 1'b0);
    end

    task automatic check_all_low(input string tag);
        check({tag, "_fx_a"}, fx_a, 1'b0);
        check({tag, "_dv_a"}, dv_a, 1'b0);
        check({tag, "_lk_a"}, lk_a, 1'b0);
        check({tag, "_fx_b"}, fx_b, 1'b0);
        check({tag, "_dv_b"}, dv_b, 1'b0);
        check({tag, "_lk_b"}, lk_b, 1'b0);
        check({tag, "_lk_c"}, lk_c, 1'b0);
        check({tag, "_lk_d"}, lk_d, 1'b0);
    endtask

    // Call right after RST_N rises at a falling edge; returns after the 16th edge.
    task automatic lock_sequence(input string tag);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clkin);
            check({tag, "_lk_a"}, lk_a, (k == 16) ? 1'b1 : 1'b0);
            check({tag, "_lk_b"}, lk_b, (k == 16) ? 1'b1 : 1'b0);
            check({tag, "_lk_c"}, lk_c, (k == 16) ? 1'b1 : 1'b0);
            check({tag, "_lk_d"}, lk_d, (k == 16) ? 1'b1 : 1'b0);
            check({tag, "_fx_a_prelock"}, fx_a, 1'b0);
            check({tag, "_dv_b_prelock"}, dv_b, 1'b0);
        end
    endtask

    initial begin
        int cnt_a;
        int cnt_d;
        int ones_b;
        int cnt_c;
        int first_c;
        int waited;

        // Step 1: reset held for 5 cycles, then lock timing
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clkin);
            check_all_low("rst");
        end
        rst_n = 1'b1;
        lock_sequence("lock1");

        // Step 2: 512 locked edges; ratios counted over the first 320
        cnt_a   = 0;
        cnt_d   = 0;
        ones_b  = 0;
        cnt_c   = 0;
        first_c = 0;
        for (int n = 1; n <= 512; n++) begin
            @(negedge clkin);
            if (n <= 6)
                check("fx_a_seq", fx_a, exp_fx_a[n-1]);
            if (n <= 8)
                check("dv_b_seq", dv_b, exp_dv_b[n-1]);
            check("dv_a_div2", dv_a, (n % 2 == 1) ? 1'b1 : 1'b0);
            check("lk_a_hold", lk_a, 1'b1);
            check("fx_d_vs_a", fx_d, fx_a);
            check("dv_d_vs_a", dv_d, dv_a);
            check("lk_d_vs_a", lk_d, lk_a);
            if (n <= 320) begin
                cnt_a  += int'(fx_a);
                cnt_d  += int'(fx_d);
                ones_b += int'(fx_b);
            end
            if (fx_c) begin
                cnt_c++;
                if (first_c == 0)
                    first_c = n;
            end
        end
        check("fx_a_count320", cnt_a, 250);
        check("fx_d_count320", cnt_d, 250);
        check("fx_b_ones320", ones_b, 320);
        check("fx_c_count512", cnt_c, 2);
        check("fx_c_first", first_c, 256);

        // Step 3: asynchronous reset between edges while CLKFX is high
        waited = 0;
        while (fx_a !== 1'b1 && waited < 40) begin
            @(negedge clkin);
            waited++;
        end
        check("fx_a_found_high", fx_a, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_low("async");
        repeat (3) begin
            @(negedge clkin);
            check_all_low("rst2");
        end
        rst_n = 1'b1;
        lock_sequence("lock2");
        for (int n = 1; n <= 6; n++) begin
            @(negedge clkin);
            check("fx_a_seq2", fx_a, exp_fx_a[n-1]);
            check("dv_b_seq2", dv_b, exp_dv_b[n-1]);
            check("fx_d_vs_a2", fx_d, fx_a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
